// File: rtl/instr_dispatch_queue.sv
// instr_dispatch_queue: classifies fetched instructions into control-unit
// start-state codes and buffers {code, IR} pairs in a DEPTH-entry FIFO with
// valid/ready handshakes on both sides. A flush discards every queued entry.
// Optional build macro DISPATCH_COND_CHECK_EN adds a flags_nzcv input; an
// instruction whose ARM condition fails against those flags is stored with
// the skip code 1 instead of its class code.
module instr_dispatch_queue #(
    parameter int STATE_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
`ifdef DISPATCH_COND_CHECK_EN
    input  logic [3:0]               flags_nzcv,
`endif
    input  logic [31:0]              ir_in,
    input  logic                     ir_valid,
    output logic                     ir_ready,
    output logic [STATE_W-1:0]       code_out,
    output logic [31:0]              code_ir,
    output logic                     code_valid,
    input  logic                     code_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (STATE_W < 6) begin : g_bad_state_w
        $error("instr_dispatch_queue: STATE_W must be >= 6");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_dispatch_queue: DEPTH must be a power of 2 and >= 2");
    end

    // Three-way split shared by the load/store families: IR24=0, else IR21=0, else.
    function automatic logic [5:0] pick3(input logic [31:0] ir, input logic [5:0] c0,
                                         input logic [5:0] c1, input logic [5:0] c2);
        if (!ir[24])      return c0;
        else if (!ir[21]) return c1;
        else              return c2;
    endfunction

    // Instruction class -> start-state code, first match wins.
    function automatic logic [5:0] classify(input logic [31:0] ir);
        if (ir == 32'd0) return 6'd0;
        if (ir[27:22] == 6'b000000 && ir[7:4] == 4'b1001) return 6'd60;
        case (ir[27:25])
            3'b000: begin
                if (!ir[4])     return (ir[24:23] == 2'b10) ? 6'd14 : 6'd10;
                else if (ir[22]) return pick3(ir, 6'd46, 6'd47, 6'd48);
                else            return pick3(ir, 6'd49, 6'd50, 6'd51);
            end
            3'b001:  return (ir[24:23] == 2'b10) ? 6'd15 : 6'd11;
            3'b010:  return pick3(ir, 6'd17, 6'd16, 6'd19);
            3'b011:  return pick3(ir, 6'd22, 6'd21, 6'd23);
            3'b100:  return ir[24] ? 6'd31 : 6'd30;
            3'b101:  return ir[24] ? 6'd44 : 6'd45;
            default: return (ir[27:24] == 4'b1111) ? 6'd61 : 6'd62;
        endcase
    endfunction

`ifdef DISPATCH_COND_CHECK_EN
    // ARM condition evaluation; NV (4'b1111) never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    logic [STATE_W-1:0] code_mem_q [DEPTH];
    logic [31:0]        ir_mem_q   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STATE_W-1:0] code_out_q, code_out_d, push_code;
    logic [31:0]        code_ir_q, code_ir_d;
    logic               push, pop;

    // Code stored for the incoming instruction, with optional condition override.
    always_comb begin
        push_code = STATE_W'(classify(ir_in));
`ifdef DISPATCH_COND_CHECK_EN
        if (ir_in != 32'd0 && !cond_pass(ir_in[31:28], flags_nzcv))
            push_code = STATE_W'(1);
`endif
    end

    assign ir_ready   = (count_q < DEPTH_C) && !flush;
    assign code_valid = (count_q != '0);
    assign push       = ir_valid && ir_ready;
    assign pop        = code_valid && code_ready;
    assign rd_next    = rd_ptr_q + PTR_W'(1);

    // Next-state for pointers, occupancy and the registered head entry.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        code_out_d = code_out_q;
        code_ir_d  = code_ir_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_next;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // Head becomes the incoming entry when the queue is (or is about to be) empty,
            // otherwise the next stored entry after a pop; an emptied queue keeps the last value.
            if (push && (count_q == '0 || (pop && count_q == CNT_W'(1)))) begin
                code_out_d = push_code;
                code_ir_d  = ir_in;
            end else if (pop && count_q > CNT_W'(1)) begin
                code_out_d = code_mem_q[rd_next];
                code_ir_d  = ir_mem_q[rd_next];
            end
        end
    end

    // Control state register with synchronous reset taking priority over flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            code_out_q <= '0;
            code_ir_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            code_out_q <= code_out_d;
            code_ir_q  <= code_ir_d;
        end
    end

    // Entry storage written on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; slots are only read once occupancy says they hold data.
        if (push) begin
            code_mem_q[wr_ptr_q] <= push_code;
            ir_mem_q[wr_ptr_q]   <= ir_in;
        end
    end

    assign code_out = code_out_q;
    assign code_ir  = code_ir_q;
    assign count    = count_q;

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Self-checking bench for instr_dispatch_queue: a queue-based reference model
// compared on every falling edge, plus directed literal expectations.
module tb_instr_dispatch_queue;

    localparam int STATE_W = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset, flush, ir_valid, code_ready;
    logic [31:0]        ir_in;
    logic               ir_ready, code_valid;
    logic [STATE_W-1:0] code_out;
    logic [31:0]        code_ir;
    logic [CNT_W-1:0]   count;
    logic [3:0]         flags_nzcv;

    always #5 clk = ~clk;

    instr_dispatch_queue #(.STATE_W(STATE_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
`ifdef DISPATCH_COND_CHECK_EN
        .flags_nzcv (flags_nzcv),
`endif
        .ir_in      (ir_in),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .code_out   (code_out),
        .code_ir    (code_ir),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .count      (count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int LS_IMM [3] = '{17, 16, 19};
    localparam int LS_REG [3] = '{22, 21, 23};
    localparam int HW_IMM [3] = '{46, 47, 48};
    localparam int HW_REG [3] = '{49, 50, 51};

    function automatic int class_code(input logic [31:0] ir);
        int sel;
        sel = ir[24] ? (ir[21] ? 2 : 1) : 0;
        if (ir == 32'd0) return 0;
        if (ir[27:22] == 6'd0 && ir[7:4] == 4'b1001) return 60;
        if (ir[27:25] == 3'b000 && !ir[4]) return (ir[24:23] == 2'b10) ? 14 : 10;
        if (ir[27:25] == 3'b001) return (ir[24:23] == 2'b10) ? 15 : 11;
        if (ir[27:25] == 3'b010) return LS_IMM[sel];
        if (ir[27:25] == 3'b011) return LS_REG[sel];
        if (ir[27:25] == 3'b000) return ir[22] ? HW_IMM[sel] : HW_REG[sel];
        if (ir[27:25] == 3'b100) return ir[24] ? 31 : 30;
        if (ir[27:25] == 3'b101) return ir[24] ? 44 : 45;
        if (ir[27:24] == 4'hF) return 61;
        return 62;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1;          default: return 0;
        endcase
    endfunction

    function automatic int stored_code(input logic [31:0] ir, input logic [3:0] f);
`ifdef DISPATCH_COND_CHECK_EN
        if (ir != 32'd0 && !cond_ok(ir[31:28], f)) return 1;
`endif
        return class_code(ir);
    endfunction

    typedef struct {
        int          code;
        logic [31:0] ir;
    } entry_t;

    entry_t mq[$];
    int     pop_log[$];
    int     exp_log[$];
    bit     model_on = 1'b0;

    // Compare DUT against the model, then advance the model by the edge to come.
    always @(negedge clk) begin
        bit m_ready, m_push, m_pop;
        if (model_on) begin
            check("cmp_ir_ready", ir_ready, (mq.size() < DEPTH) && !flush);
            check("cmp_code_valid", code_valid, mq.size() != 0);
            check("cmp_count", count, mq.size());
            if (mq.size() != 0) begin
                check("cmp_code_out", code_out, mq[0].code);
                check("cmp_code_ir", code_ir, mq[0].ir);
            end
        end
        if (reset || flush) begin
            mq.delete();
        end else begin
            m_ready = mq.size() < DEPTH;
            m_pop   = (mq.size() != 0) && code_ready;
            m_push  = ir_valid && m_ready;
            if (code_valid && code_ready) pop_log.push_back(int'(code_out));
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{stored_code(ir_in, flags_nzcv), ir_in});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input logic [31:0] ir);
        bit done;
        done = 1'b0;
        ir_valid = 1'b1;
        ir_in    = ir;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (ir_ready) done = 1'b1;
            tick();
        end
        ir_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic drain();
        code_ready = 1'b1;
        ir_valid   = 1'b0;
        for (int i = 0; i < 20 && count != '0; i++) tick();
        code_ready = 1'b0;
        check("drain_empty", count, 0);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, pop_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < pop_log.size(); i++)
            check(name, pop_log[i], exp_log[i]);
        pop_log.delete();
    endtask

    logic [31:0] wrap_tbl [6];
    int          wrap_exp [6];

    initial begin
        wrap_tbl = '{32'hE0812003, 32'hE5912004, 32'hE4912004, 32'hEA000010, 32'hE0000091, 32'hE1D120B4};
        wrap_exp = '{10, 16, 17, 45, 60, 47};
        reset = 1'b1; flush = 1'b0; ir_valid = 1'b0; code_ready = 1'b0;
        ir_in = '0; flags_nzcv = 4'b0000;
        tick();
        model_on = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_valid", code_valid, 0);
        check("rst_code_out", code_out, 0);
        check("rst_code_ir", code_ir, 0);
        check("rst_ir_ready", ir_ready, 1);

        // Single push into an empty queue, consumer stalled.
`ifdef DISPATCH_COND_CHECK_EN
        flags_nzcv = 4'b0000;
`endif
        push_wait(32'hE0812003);
        check("p1_valid", code_valid, 1);
        check("p1_code", code_out, 10);
        check("p1_ir", code_ir, 32'hE0812003);
        check("p1_count", count, 1);
        drain();
        pop_log.delete();

        // Load/store and branch classes; fifth push stalls until a pop.
        push_wait(32'hE5912004);
        push_wait(32'hE4912004);
        push_wait(32'hE5B12004);
        push_wait(32'hEA000010);
        ir_valid = 1'b1; ir_in = 32'hEB000010;
        #1;
        check("full_ready", ir_ready, 0);
        check("full_count", count, 4);
        tick();
        check("full_hold", ir_ready, 0);
        code_ready = 1'b1;
        push_wait(32'hEB000010);
        drain();
        exp_log = '{16, 17, 19, 45, 44};
        check_log("order_ls");

        // Multiply/SWI/undefined/zero fill, then pop+push on a full queue.
        push_wait(32'hE0000091);
        push_wait(32'hEF000000);
        push_wait(32'hEC000000);
        push_wait(32'h00000000);
        check("fill_count", count, 4);
        check("fill_ready", ir_ready, 0);
        code_ready = 1'b1; ir_valid = 1'b1; ir_in = 32'hE3A00001;
        #1;
        check("nopass_ready", ir_ready, 0);
        tick();
        check("nopass_count", count, 3);
        check("nopass_rise", ir_ready, 1);
        code_ready = 1'b0;
        tick();
        ir_valid = 1'b0;
        check("nopass_accept", count, 4);
        drain();
        exp_log = '{60, 61, 62, 0, 11};
        check_log("order_misc");

        // Streaming push/pop through the pointer wrap.
        code_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ir_valid = 1'b1;
            ir_in    = wrap_tbl[i % 6];
            tick();
            check("wrap_count", count <= 1, 1);
        end
        ir_valid = 1'b0;
        tick();
        tick();
        check("wrap_empty", count, 0);
        exp_log.delete();
        for (int i = 0; i < 12; i++) exp_log.push_back(wrap_exp[i % 6]);
        check_log("order_wrap");
        code_ready = 1'b0;

        // Flush with three entries queued while a push is offered.
        push_wait(32'hE0812003);
        push_wait(32'hE5912004);
        push_wait(32'hEA000010);
        flush = 1'b1; ir_valid = 1'b1; ir_in = 32'hE1D120B4;
        #1;
        check("flush_ready", ir_ready, 0);
        tick();
        flush = 1'b0; ir_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_valid", code_valid, 0);
        push_wait(32'hE1D120B4);
        check("flush_push", code_out, 47);
        drain();

        // Condition check (or unconditional classification in the default build).
        flags_nzcv = 4'b0000;
        push_wait(32'h00812003);
`ifdef DISPATCH_COND_CHECK_EN
        check("cond_fail", code_out, 1);
`else
        check("cond_none", code_out, 10);
`endif
        drain();
        flags_nzcv = 4'b0100;
        push_wait(32'h00812003);
        check("cond_pass", code_out, 10);
        drain();
        flags_nzcv = 4'b0000;
        push_wait(32'h00000000);
        check("cond_zero", code_out, 0);
        drain();

        // Reset with two entries queued.
        push_wait(32'hE5912004);
        push_wait(32'hEF000000);
        check("prerst_count", count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_count", count, 0);
        check("midrst_valid", code_valid, 0);
        check("midrst_code", code_out, 0);
        check("midrst_ir", code_ir, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
